// File: rtl/contador_down_timer_if.sv
// Control/status bundle for the loadable down-counting timer.
// The master drives the commands; the slave (the timer) returns count and flags.
interface contador_down_timer_if #(
   parameter int WIDTH = 32
);
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic             stop;
   logic             down;
   logic             auto_reload;
   logic             clear_expired;
   logic [WIDTH-1:0] q;
   logic             running;
   logic             done;
   logic             expired;

   modport master (
      output load, load_val, start, stop, down, auto_reload, clear_expired,
      input  q, running, done, expired
   );

   modport slave (
      input  load, load_val, start, stop, down, auto_reload, clear_expired,
      output q, running, done, expired
   );
endinterface

// File: rtl/contador_down_timer.sv
// Loadable down-counting timer with start/stop/hold, terminal-count pulse,
// sticky expiry flag and optional auto-reload from the last loaded value.
module contador_down_timer #(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   contador_down_timer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;
   logic             expired_q, expired_d;

   // NOTE: reset is asynchronous and active-low; every flop, including the
   // reload register, gets a defined value so an aborted count leaves no residue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         q_q       <= '0;
         reload_q  <= '0;
         done_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q   <= state_d;
         q_q       <= q_d;
         reload_q  <= reload_d;
         done_q    <= done_d;
         expired_q <= expired_d;
      end
   end

   always_comb begin
      // NOTE: every target gets a default first so no latch is inferred.
      state_d   = state_q;
      q_d       = q_q;
      reload_d  = reload_q;
      done_d    = 1'b0;
      expired_d = expired_q;

      if (bus.clear_expired) begin
         expired_d = 1'b0;
      end

      // Strict priority: load, then stop, then start, then the down tick.
      if (bus.load) begin
         q_d       = bus.load_val;
         reload_d  = bus.load_val;
         state_d   = IDLE;
         expired_d = 1'b0;
      end else if (bus.stop) begin
         if (state_q == RUN) begin
            state_d = HOLD;
         end
      end else if (bus.start) begin
         if ((state_q != RUN) && (q_q != '0)) begin
            state_d = RUN;
         end
      end else if (bus.down && (state_q == RUN)) begin
         if (q_q == WIDTH'(1)) begin
            // Terminal tick: the expiry set overrides a coincident clear.
            done_d    = 1'b1;
            expired_d = 1'b1;
            if (bus.auto_reload && (reload_q != '0)) begin
               q_d = reload_q;
            end else begin
               q_d     = '0;
               state_d = IDLE;
            end
         end else begin
            q_d = q_q - WIDTH'(1);
         end
      end
   end

   always_comb begin
      bus.q       = q_q;
      bus.running = (state_q == RUN);
      bus.done    = done_q;
      bus.expired = expired_q;
   end

endmodule

// File: tb/tb_contador_down_timer.sv
// Self-checking bench: directed scenarios plus random commands, each cycle
// compared against a behavioural model of the timer.
module tb_contador_down_timer;

   localparam int W = 32;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   // Behavioural model: remaining count, reload value, activity mode, flags.
   typedef enum int {M_IDLE, M_RUN, M_HOLD} mode_e;
   mode_e        m_mode;
   logic [W-1:0] m_q;
   logic [W-1:0] m_rel;
   logic         m_done;
   logic         m_exp;

   contador_down_timer_if #(.WIDTH(W)) bus ();

   contador_down_timer #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                  tag, got, got, exp, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_q    = '0;
      m_rel  = '0;
      m_done = 1'b0;
      m_exp  = 1'b0;
   endtask

   task automatic model_step(input logic ld, input logic [W-1:0] lv, input logic st,
                             input logic sp, input logic dn, input logic ar,
                             input logic clr);
      m_done = 1'b0;
      if (clr) m_exp = 1'b0;
      if (ld) begin
         m_q    = lv;
         m_rel  = lv;
         m_mode = M_IDLE;
         m_exp  = 1'b0;
      end else if (sp) begin
         if (m_mode == M_RUN) m_mode = M_HOLD;
      end else if (st) begin
         if (m_mode != M_RUN && m_q != 0) m_mode = M_RUN;
      end else if (dn && m_mode == M_RUN) begin
         // One tick consumed; reaching zero is the terminal event.
         if (m_q - 1 == 0) begin
            m_done = 1'b1;
            m_exp  = 1'b1;
            if (ar && m_rel != 0) begin
               m_q = m_rel;
            end else begin
               m_q    = '0;
               m_mode = M_IDLE;
            end
         end else begin
            m_q = m_q - 1;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".q"},       bus.q,       m_q);
      check({tag, ".running"}, W'(bus.running), W'(m_mode == M_RUN));
      check({tag, ".done"},    W'(bus.done),    W'(m_done));
      check({tag, ".expired"}, W'(bus.expired), W'(m_exp));
   endtask

   // Apply one cycle of commands at the falling edge, sample after the next one.
   task automatic step(input string tag, input logic ld, input logic [W-1:0] lv,
                       input logic st, input logic sp, input logic dn,
                       input logic ar, input logic clr);
      bus.load          = ld;
      bus.load_val      = lv;
      bus.start         = st;
      bus.stop          = sp;
      bus.down          = dn;
      bus.auto_reload   = ar;
      bus.clear_expired = clr;
      model_step(ld, lv, st, sp, dn, ar, clr);
      @(posedge clk);
      @(negedge clk);
      compare_all(tag);
   endtask

   task automatic do_load(input logic [W-1:0] v);
      step("load", 1'b1, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_start();
      step("start", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_down(input logic ar);
      step("down", 1'b0, '0, 1'b0, 1'b0, 1'b1, ar, 1'b0);
   endtask

   initial begin
      int pulses;
      int r;
      logic         ld, st, sp, dn, ar, clr;
      logic [W-1:0] lv;

      n_vec = 0;
      n_err = 0;
      rst   = 1'b0;
      bus.load = 1'b0; bus.load_val = '0; bus.start = 1'b0; bus.stop = 1'b0;
      bus.down = 1'b0; bus.auto_reload = 1'b0; bus.clear_expired = 1'b0;
      model_reset();

      // Reset state
      repeat (2) @(negedge clk);
      check("rst.q",       bus.q,           '0);
      check("rst.running", W'(bus.running), '0);
      check("rst.done",    W'(bus.done),    '0);
      check("rst.expired", W'(bus.expired), '0);
      rst = 1'b1;
      @(negedge clk);

      // Basic countdown 3,2,1,0
      do_load(3);
      check("basic.q3", bus.q, 3);
      do_start();
      do_down(1'b0);
      check("basic.q2", bus.q, 2);
      do_down(1'b0);
      check("basic.q1", bus.q, 1);
      do_down(1'b0);
      check("basic.q0",      bus.q,           0);
      check("basic.done",    W'(bus.done),    1);
      check("basic.expired", W'(bus.expired), 1);
      check("basic.running", W'(bus.running), 0);
      do_down(1'b0);
      check("basic.done_once", W'(bus.done), 0);

      // Pause and resume
      do_load(10);
      do_start();
      repeat (4) do_down(1'b0);
      step("stop", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (5) do_down(1'b0);
      check("pause.q",       bus.q,           6);
      check("pause.running", W'(bus.running), 0);
      do_start();
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         do_down(1'b0);
         if (bus.done) pulses++;
      end
      check("pause.q_end",  bus.q,     0);
      check("pause.pulses", W'(pulses), 1);

      // Auto-reload with load 2: 2,1,2,1,... three terminal pulses in six ticks
      do_load(2);
      do_start();
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         do_down(1'b1);
         if (bus.done) pulses++;
         check("ar.running", W'(bus.running), 1);
      end
      check("ar.pulses", W'(pulses), 3);
      check("ar.q",      bus.q,      2);

      // Auto-reload with reload=1: every tick is terminal
      do_load(1);
      do_start();
      for (int i = 0; i < 3; i++) begin
         do_down(1'b1);
         check("ar1.q",    bus.q,        1);
         check("ar1.done", W'(bus.done), 1);
      end

      // Load beats a coincident terminal tick
      do_load(5);
      do_start();
      repeat (4) do_down(1'b0);
      check("prio.q1", bus.q, 1);
      step("load_vs_tick", 1'b1, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("prio.q5",      bus.q,           5);
      check("prio.running", W'(bus.running), 0);
      check("prio.done",    W'(bus.done),    0);

      // start with q=0 is ignored; stop beats start
      do_load(0);
      do_start();
      check("zero.running", W'(bus.running), 0);
      do_load(4);
      step("stop_start", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("ss.running", W'(bus.running), 0);

      // Sticky flag and clear/set collision
      do_load(1);
      do_start();
      do_down(1'b0);
      check("sticky.set", W'(bus.expired), 1);
      step("clr", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("sticky.clr", W'(bus.expired), 0);
      do_load(2);
      do_start();
      do_down(1'b0);
      step("clr_vs_tick", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      check("sticky.collide", W'(bus.expired), 1);

      // Full-range load
      do_load('1);
      do_start();
      repeat (3) do_down(1'b0);
      check("full.q", bus.q, 32'hFFFF_FFFC);

      // Asynchronous reset mid-run
      do_load(100);
      do_start();
      repeat (10) do_down(1'b0);
      bus.down = 1'b1;
      #2 rst = 1'b0;
      model_reset();
      #1;
      check("arst.q",       bus.q,           0);
      check("arst.running", W'(bus.running), 0);
      check("arst.done",    W'(bus.done),    0);
      check("arst.expired", W'(bus.expired), 0);
      @(negedge clk);
      bus.down = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      // Random commands against the model
      for (int i = 0; i < 3000; i++) begin
         r   = int'($urandom_range(0, 99));
         ld  = (r < 5);
         r   = int'($urandom_range(0, 99));
         sp  = (r < 6);
         r   = int'($urandom_range(0, 99));
         st  = (r < 15);
         r   = int'($urandom_range(0, 99));
         dn  = (r < 75);
         ar  = 1'($urandom_range(0, 1));
         r   = int'($urandom_range(0, 99));
         clr = (r < 8);
         r   = int'($urandom_range(0, 19));
         if (r == 0)      lv = '1;
         else if (r == 1) lv = $urandom;
         else             lv = W'($urandom_range(0, 7));
         step("rand", ld, lv, st, sp, dn, ar, clr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
